// File: rtl/multdiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide, MTHI/MTLO.
// Define MULTDIV_FAST_MUL_EN to replace the 32-cycle multiply with a two-stage pipelined multiplier.
`timescale 1ns/1ps
module multdiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] acc_hi_q, acc_lo_q;
  logic [31:0] opnd_q;
  logic        res_neg_q, rem_neg_q;

  logic        req_mul, req_div, req_signed, accept, last_iter;
  logic [31:0] mag_a, mag_b;

  assign req_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign req_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign req_signed = (op == OP_MULT) || (op == OP_DIV);
  assign accept     = valid_i && !flush && (state_q == S_IDLE);
  assign last_iter  = (cnt_q == 5'd31);

  assign mag_a = (req_signed && a[31]) ? (32'd0 - a) : a;
  assign mag_b = (req_signed && b[31]) ? (32'd0 - b) : b;

  // Multiplier datapath: produces the (unsigned) product for this cycle's commit.
  logic [63:0] mul_prod, mul_res;
`ifdef MULTDIV_FAST_MUL_EN
  logic [31:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;

  assign mul_prod = {pp_hh_q, 32'd0}
                  + {16'd0, pp_hl_q, 16'd0}
                  + {16'd0, pp_lh_q, 16'd0}
                  + {32'd0, pp_ll_q};
`else
  logic [32:0] mul_sum;

  // acc_hi holds the partial product, acc_lo the multiplier being shifted out.
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_prod = {mul_sum, acc_lo_q[31:1]};
`endif
  assign mul_res = res_neg_q ? (64'd0 - mul_prod) : mul_prod;

  // Restoring divider step: acc_hi is the remainder, acc_lo shifts dividend out / quotient in.
  logic [33:0] div_trial;
  logic        div_no_borrow;
  logic [31:0] div_rem_nx, div_quo_nx;
  logic        unused_bits;

  assign div_trial     = {1'b0, acc_hi_q, acc_lo_q[31]} - {2'b0, opnd_q};
  assign div_no_borrow = ~div_trial[33];
  assign div_rem_nx    = div_no_borrow ? div_trial[31:0] : {acc_hi_q[30:0], acc_lo_q[31]};
  assign div_quo_nx    = {acc_lo_q[30:0], div_no_borrow};
  assign unused_bits   = div_trial[32];

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = valid_i && !flush && (req_mul || req_div);
        if (valid_i && !flush) begin
          if (req_mul) begin
            state_d = S_MUL;
          end else if (req_div) begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
`ifdef MULTDIV_FAST_MUL_EN
          state_d = S_DONE;
`else
          if (last_iter) state_d = S_DONE;
`endif
        end
      end
      S_DIV: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      opnd_q    <= 32'd0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
`ifdef MULTDIV_FAST_MUL_EN
      pp_ll_q   <= 32'd0;
      pp_lh_q   <= 32'd0;
      pp_hl_q   <= 32'd0;
      pp_hh_q   <= 32'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= 5'd0;
          if (accept) begin
            case (op)
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
            // A zero divisor keeps the quotient all-ones and the remainder equal to a.
            res_neg_q <= req_signed && (a[31] ^ b[31]) && (b != 32'd0);
            rem_neg_q <= req_signed && a[31];
            acc_hi_q  <= 32'd0;
            if (req_div) begin
              acc_lo_q <= mag_a;
              opnd_q   <= mag_b;
            end else begin
              acc_lo_q <= mag_b;
              opnd_q   <= mag_a;
            end
`ifdef MULTDIV_FAST_MUL_EN
            pp_ll_q <= {16'd0, mag_a[15:0]}  * {16'd0, mag_b[15:0]};
            pp_lh_q <= {16'd0, mag_a[15:0]}  * {16'd0, mag_b[31:16]};
            pp_hl_q <= {16'd0, mag_a[31:16]} * {16'd0, mag_b[15:0]};
            pp_hh_q <= {16'd0, mag_a[31:16]} * {16'd0, mag_b[31:16]};
`endif
          end
        end
        S_MUL: begin
          if (!flush) begin
`ifdef MULTDIV_FAST_MUL_EN
            hi_q <= mul_res[63:32];
            lo_q <= mul_res[31:0];
`else
            acc_hi_q <= mul_prod[63:32];
            acc_lo_q <= mul_prod[31:0];
            cnt_q    <= cnt_q + 5'd1;
            if (last_iter) begin
              hi_q <= mul_res[63:32];
              lo_q <= mul_res[31:0];
            end
`endif
          end
        end
        S_DIV: begin
          if (!flush) begin
            acc_hi_q <= div_rem_nx;
            acc_lo_q <= div_quo_nx;
            cnt_q    <= cnt_q + 5'd1;
            if (last_iter) begin
              lo_q <= res_neg_q ? (32'd0 - div_quo_nx) : div_quo_nx;
              hi_q <= rem_neg_q ? (32'd0 - div_rem_nx) : div_rem_nx;
            end
          end
        end
        default: cnt_q <= 5'd0;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide port: valid_i  input  1  request from execute stage, sampled every cycle.
REQ-004 SHALL provide port: op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-005 SHALL provide port: a  input  32  operand A (rs / dividend / MTHI-MTLO source).
REQ-006 SHALL provide port: b  input  32  operand B (rt / divisor).
REQ-007 SHALL provide port: flush  input  1  abort in-flight operation, drop same-cycle request.
REQ-008 SHALL provide port: busy  output  1  stall request to pipeline (combinational).
REQ-009 SHALL provide port: done  output  1  one-cycle pulse, result committed to hi/lo.
REQ-010 SHALL provide port: hi  output  32  architectural HI register (registered).
REQ-011 SHALL provide port: lo  output  32  architectural LO register (registered).

Function
REQ-012 SHALL accept a request on a rising edge where valid_i=1, flush=0, state=IDLE.
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE: IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU; MUL/DIV->DONE after final iteration; DONE->IDLE unconditionally.
REQ-014 SHALL write MTHI (hi<=a) / MTLO (lo<=a) on the accepting edge, stay in IDLE, busy=0, done=0.
REQ-015 SHALL drive busy = (state==MUL or state==DIV) OR (state==IDLE and valid_i and op in {1..4} and not flush); busy=0 in DONE.
REQ-016 SHALL ignore valid_i while state!=IDLE (execute holds the request stable while busy=1).
REQ-017 SHALL latch a, b, op and operand signs on acceptance; later input changes have no effect.
REQ-018 SHALL run 32 iterations for MUL (radix-2 shift-add on magnitudes) and DIV (restoring, one quotient bit per cycle) via a 5-bit counter 0..31 wrapping to DONE.
REQ-019 SHALL, for acceptance edge at cycle T, assert done during cycle T+33 with hi/lo already holding the result in that cycle.
REQ-020 SHALL produce {hi,lo} = full 64-bit product; MULT signed, MULTU unsigned.
REQ-021 SHALL produce lo=quotient, hi=remainder; DIV: quotient truncated toward zero, negated when signs differ, remainder takes sign of a; DIVU unsigned.
REQ-022 SHALL on divide-by-zero (DIV or DIVU, b=0) complete normally with lo=0xFFFFFFFF, hi=a; no exception raised.
REQ-023 SHALL handle DIV 0x80000000 / 0xFFFFFFFF without hang: lo=0x80000000, hi=0.
REQ-024 SHALL on flush=1 in MUL/DIV return to IDLE next edge, leave hi/lo unchanged, never pulse done for that operation.
REQ-025 SHALL on flush=1 in DONE complete normally (result already committed).
REQ-026 SHALL treat flush=1 and valid_i=1 in IDLE as no request, including MTHI/MTLO.

Reset
REQ-027 SHALL on reset=1 at an edge set state=IDLE, hi=0, lo=0, counter=0, done=0, regardless of state; reset mid-operation discards it with no done.
REQ-028 SHALL drive busy=0 during and immediately after reset unless a new valid request is present.
REQ-029 SHALL give reset priority over flush and valid_i.

Configuration
REQ-030 SHALL, with MULTDIV_FAST_MUL_EN defined, compute MULT/MULTU with a two-stage pipelined 32x32 multiplier: MUL lasts 1 cycle, done at T+2; DIV timing unchanged.
REQ-031 SHALL, without MULTDIV_FAST_MUL_EN, use the 32-iteration shift-add of REQ-018; results identical in both builds.

Verification
REQ-032 SHALL cover: MULT a=0xFFFFFFFD, b=5 -> done at T+33 (T+2 fast), hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-033 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-034 SHALL cover: DIV accepted, flush at T+10 -> state IDLE at T+11, no done, hi/lo keep prior values; new MULT accepted at T+11 completes normally.
REQ-035 SHALL cover: reset asserted at T+20 of DIVU -> hi=lo=0, busy=0, done never pulses.
REQ-036 SHALL cover: MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 back-to-back -> hi/lo updated on each accepting edge, busy stays 0.
REQ-037 SHALL cover: valid_i with op changed to DIVU while MUL busy -> ignored; MUL result correct; busy=1 every cycle T..T+32.
